// File: rtl/window_gen_pkg.sv
// Shared convolution types: default kernel/pixel sizes, the packed window layout
// consumed by the processing element, and the raster-position phase encoding.
package conv_pkg;

  localparam int unsigned KERNEL_SIZE = 3;
  localparam int unsigned PX_SIZE     = 8;

  typedef logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PX_SIZE-1:0] window_t;

  typedef enum logic [1:0] {
    StFill,
    StRowWarm,
    StStream
  } phase_e;

  // Phase of the pixel that will land at (col, row) for a kernel of size k.
  function automatic phase_e phase_of(input int unsigned col, input int unsigned row,
                                      input int unsigned k);
    if (row < k - 1) return StFill;
    if (col < k - 1) return StRowWarm;
    return StStream;
  endfunction

endpackage

// File: rtl/window_gen_if.sv
// Pixel-in / window-out stream bundle for window_gen. The slave modport is the
// generator itself; the master modport is the upstream/downstream environment.
interface window_gen_if #(
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned PX_SIZE     = 8,
  parameter int unsigned IMG_WIDTH   = 64,
  parameter int unsigned IMG_HEIGHT  = 64
);

  logic                                                in_valid;
  logic                                                in_ready;
  logic [PX_SIZE-1:0]                                  in_px;
  logic                                                out_valid;
  logic                                                out_ready;
  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PX_SIZE-1:0] out_window;
  logic [$clog2(IMG_WIDTH)-1:0]                        out_x;
  logic [$clog2(IMG_HEIGHT)-1:0]                       out_y;
  logic                                                out_last;

  modport master (
    output in_valid, in_px, out_ready,
    input  in_ready, out_valid, out_window, out_x, out_y, out_last
  );

  modport slave (
    input  in_valid, in_px, out_ready,
    output in_ready, out_valid, out_window, out_x, out_y, out_last
  );

endinterface

// File: rtl/window_gen_line_buffer.sv
// Single image-row delay: dout is the pixel written IMG_WIDTH enables ago.
// Storage is deliberately unreset; stale contents are never emitted.
module line_buffer #(
  parameter int unsigned IMG_WIDTH = 64,
  parameter int unsigned PX_SIZE   = 8
) (
  input  logic               clk,
  input  logic               en,
  input  logic [PX_SIZE-1:0] din,
  output logic [PX_SIZE-1:0] dout
);

  logic [IMG_WIDTH-1:0][PX_SIZE-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (en) mem_q <= {mem_q[IMG_WIDTH-2:0], din};
  end

  assign dout = mem_q[IMG_WIDTH-1];

endmodule

// File: rtl/window_gen.sv
// Raster-to-window generator: buffers K-1 rows and emits every fully populated
// KxK neighbourhood, indexed [x][y], through a single-slot output register.
module window_gen #(
  parameter int unsigned KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
  parameter int unsigned PX_SIZE     = conv_pkg::PX_SIZE,
  parameter int unsigned IMG_WIDTH   = 64,
  parameter int unsigned IMG_HEIGHT  = 64
) (
  input logic         clk,
  input logic         rst,
  window_gen_if.slave bus
);

  import conv_pkg::*;

  localparam int unsigned XW  = $clog2(IMG_WIDTH);
  localparam int unsigned YW  = $clog2(IMG_HEIGHT);
  localparam int unsigned KM1 = KERNEL_SIZE - 1;

  typedef logic [KERNEL_SIZE-1:0][PX_SIZE-1:0]                   column_t;
  typedef logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PX_SIZE-1:0] win_t;

  logic [XW-1:0]      col_q, col_d;
  logic [YW-1:0]      row_q, row_d;
  phase_e             phase_q;
  logic               accept, emit;
  logic [PX_SIZE-1:0] tap [KERNEL_SIZE];
  column_t            col_vec;
  win_t               win_q, win_d;

  logic               out_valid_q;
  logic               out_last_q;
  logic [XW-1:0]      out_x_q;
  logic [YW-1:0]      out_y_q;
  win_t               out_win_q;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign emit         = accept && (phase_q == StStream);

  // tap[j] is the pixel j rows above the incoming one, same column.
  assign tap[0] = bus.in_px;
  for (genvar j = 0; j < KM1; j++) begin : g_lb
    line_buffer #(
      .IMG_WIDTH (IMG_WIDTH),
      .PX_SIZE   (PX_SIZE)
    ) u_lb (
      .clk  (clk),
      .en   (accept),
      .din  (tap[j]),
      .dout (tap[j+1])
    );
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (col_q == XW'(IMG_WIDTH - 1)) begin
      col_d = '0;
      row_d = (row_q == YW'(IMG_HEIGHT - 1)) ? '0 : row_q + 1'b1;
    end else begin
      col_d = col_q + 1'b1;
    end

    for (int j = 0; j < KERNEL_SIZE; j++) begin
      col_vec[KM1-j] = tap[j];
    end

    win_d = win_q;
    for (int x = 0; x < KM1; x++) begin
      win_d[x] = win_q[x+1];
    end
    win_d[KM1] = col_vec;
  end

  // Window shift register needs no reset: emission requires K fresh columns.
  always_ff @(posedge clk) begin
    if (accept) win_q <= win_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      phase_q     <= StFill;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_win_q   <= '0;
    end else begin
      if (accept) begin
        col_q   <= col_d;
        row_q   <= row_d;
        phase_q <= phase_of(32'(col_d), 32'(row_d), KERNEL_SIZE);
      end
      if (emit) begin
        out_valid_q <= 1'b1;
        out_win_q   <= win_d;
        out_x_q     <= col_q - XW'(KM1);
        out_y_q     <= row_q - YW'(KM1);
        out_last_q  <= (col_q == XW'(IMG_WIDTH - 1)) && (row_q == YW'(IMG_HEIGHT - 1));
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_window = out_win_q;
  assign bus.out_x      = out_x_q;
  assign bus.out_y      = out_y_q;
  assign bus.out_last   = out_last_q;

endmodule

// File: tb/tb_window_gen.sv
// Bench for window_gen: a 5x4 K=3 instance checked every cycle against an
// image-array reference model, plus a 5x5 K=5 instance with literal checks.
module tb_window_gen;

  localparam int AW = 5;
  localparam int AH = 4;
  localparam int AK = 3;

  typedef logic [AK-1:0][AK-1:0][7:0] awin_t;
  typedef struct {
    awin_t      win;
    logic [2:0] x;
    logic [1:0] y;
    logic       last;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  window_gen_if #(.KERNEL_SIZE(AK), .PX_SIZE(8), .IMG_WIDTH(AW), .IMG_HEIGHT(AH)) ifa ();
  window_gen_if #(.KERNEL_SIZE(5), .PX_SIZE(8), .IMG_WIDTH(5), .IMG_HEIGHT(5)) ifb ();

  window_gen #(.KERNEL_SIZE(AK), .PX_SIZE(8), .IMG_WIDTH(AW), .IMG_HEIGHT(AH)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  window_gen #(.KERNEL_SIZE(5), .PX_SIZE(8), .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: image array indexed by raster position; a window is due
  // whenever the accepted pixel completes a KxK block inside the image.
  rec_t       exp_q[$];
  rec_t       got_q[$];
  logic [7:0] img [AH][AW];
  int         m_col = 0;
  int         m_row = 0;
  bit         prev_stall = 0;
  rec_t       held;
  bit         rand_ready = 0;
  int         b_count = 0;

  always @(negedge clk) begin
    rec_t cur;
    rec_t e;
    cur.win  = ifa.out_window;
    cur.x    = ifa.out_x;
    cur.y    = ifa.out_y;
    cur.last = ifa.out_last;
    if (rst) begin
      exp_q.delete();
      m_col      = 0;
      m_row      = 0;
      prev_stall = 0;
    end else begin
      chk("in_ready", ifa.in_ready, !ifa.out_valid || ifa.out_ready);
      chk("out_valid_vs_model", ifa.out_valid, exp_q.size() != 0);
      if (prev_stall) begin
        chk("stall_window", cur.win, held.win);
        chk("stall_pos", {cur.x, cur.y, cur.last}, {held.x, held.y, held.last});
      end
      if (ifa.out_valid && ifa.out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("window", cur.win, e.win);
        chk("out_x", cur.x, e.x);
        chk("out_y", cur.y, e.y);
        chk("out_last", cur.last, e.last);
        got_q.push_back(cur);
      end
      prev_stall = ifa.out_valid && !ifa.out_ready;
      held       = cur;
      if (ifa.in_valid && ifa.in_ready) begin
        img[m_row][m_col] = ifa.in_px;
        if (m_col >= AK - 1 && m_row >= AK - 1) begin
          for (int x = 0; x < AK; x++)
            for (int y = 0; y < AK; y++)
              e.win[x][y] = img[m_row-AK+1+y][m_col-AK+1+x];
          e.x    = 3'(m_col - AK + 1);
          e.y    = 2'(m_row - AK + 1);
          e.last = (m_col == AW - 1) && (m_row == AH - 1);
          exp_q.push_back(e);
        end
        m_col++;
        if (m_col == AW) begin
          m_col = 0;
          m_row = (m_row == AH - 1) ? 0 : m_row + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ifb.out_valid && ifb.out_ready) b_count++;
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) ifa.out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic send(input logic [7:0] v, input int max_gap);
    bit acc;
    int waited;
    if (max_gap > 0) begin
      repeat ($urandom_range(0, max_gap)) begin
        ifa.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    ifa.in_valid = 1'b1;
    ifa.in_px    = v;
    waited       = 0;
    do begin
      @(negedge clk);
      acc = ifa.in_ready;
      @(posedge clk); #1;
      waited++;
    end while (!acc && waited < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: pixel %0d not accepted after %0d cycles", v, waited);
    end
    ifa.in_valid = 1'b0;
  endtask

  task automatic stream(input int base, input int n, input int max_gap);
    for (int i = 0; i < n; i++) send(8'(base + i), max_gap);
  endtask

  task automatic drain();
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int   base;
    int   nlast;
    logic [7:0] minpx;

    ifa.in_valid  = 1'b0;
    ifa.in_px     = '0;
    ifa.out_ready = 1'b1;
    ifb.in_valid  = 1'b0;
    ifb.in_px     = '0;
    ifb.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_out_last", ifa.out_last, 0);
    chk("rst_out_x", ifa.out_x, 0);
    chk("rst_out_y", ifa.out_y, 0);
    chk("rst_out_window", ifa.out_window, 0);
    chk("rst_in_ready", ifa.in_ready, 1);

    // Raster 0..19, out_ready high: one-cycle latency, one window per STREAM pixel.
    for (int i = 0; i < 20; i++) begin
      ifa.in_valid = 1'b1;
      ifa.in_px    = 8'(i);
      @(posedge clk); #1;
      chk("emit_latency", ifa.out_valid, (i % AW >= 2) && (i / AW >= 2));
    end
    drain();
    chk("t1_count", got_q.size(), 6);
    if (got_q.size() == 6) begin
      chk("t1_w0_00", got_q[0].win[0][0], 0);
      chk("t1_w0_10", got_q[0].win[1][0], 1);
      chk("t1_w0_01", got_q[0].win[0][1], 5);
      chk("t1_w0_22", got_q[0].win[2][2], 12);
      chk("t1_w0_xy", {got_q[0].x, got_q[0].y}, 0);
      nlast = 0;
      foreach (got_q[i]) if (got_q[i].last) nlast++;
      chk("t1_last_count", nlast, 1);
      chk("t1_w5_last", got_q[5].last, 1);
      chk("t1_w5_xy", {got_q[5].x, got_q[5].y}, {3'd2, 2'd1});
      chk("t1_w5_22", got_q[5].win[2][2], 19);
    end

    // Stall on the second window for three cycles with a pixel waiting.
    base = got_q.size();
    for (int i = 0; i < 13; i++) send(8'(i), 0);
    send(8'd13, 0);
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_px     = 8'd14;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_in_ready", ifa.in_ready, 0);
      chk("stall_out_valid", ifa.out_valid, 1);
      chk("stall_out_x", ifa.out_x, 1);
      chk("stall_px22", ifa.out_window[2][2], 13);
      @(posedge clk); #1;
    end
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    stream(15, 5, 0);
    drain();
    chk("t2_count", got_q.size() - base, 6);

    // Random gaps and out_ready toggling over 25 frames of random pixels.
    base       = got_q.size();
    rand_ready = 1;
    for (int f = 0; f < 25; f++)
      for (int i = 0; i < AW * AH; i++) send(8'($urandom), 2);
    rand_ready = 0;
    @(posedge clk); #1;
    drain();
    chk("t3_count", got_q.size() - base, 150);
    nlast = 0;
    for (int i = base; i < got_q.size(); i++) if (got_q[i].last) nlast++;
    chk("t3_last_count", nlast, 25);

    // Back-to-back frames: second frame windows hold only second-frame pixels.
    base = got_q.size();
    stream(0, 20, 0);
    stream(100, 20, 0);
    drain();
    chk("t4_count", got_q.size() - base, 12);
    if (got_q.size() - base == 12) begin
      chk("t4_f2_w0_00", got_q[base+6].win[0][0], 100);
      minpx = 8'hff;
      for (int w = base + 6; w < base + 12; w++)
        for (int x = 0; x < AK; x++)
          for (int y = 0; y < AK; y++)
            if (got_q[w].win[x][y] < minpx) minpx = got_q[w].win[x][y];
      chk("t4_f2_min_px", minpx, 100);
    end

    // Reset with a window pending, then the same frame again.
    stream(0, 14, 0);
    ifa.out_ready = 1'b0;
    chk("t5_pending", ifa.out_valid, 1);
    base = got_q.size();
    rst  = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_rst_out_valid", ifa.out_valid, 0);
    chk("t5_rst_in_ready", ifa.in_ready, 1);
    chk("t5_rst_xy", {ifa.out_x, ifa.out_y, ifa.out_last}, 0);
    ifa.out_ready = 1'b1;
    stream(0, 20, 0);
    drain();
    chk("t5_count", got_q.size() - base, 6);
    if (got_q.size() - base == 6) begin
      for (int w = 0; w < 6; w++) begin
        chk("t5_window", got_q[base+w].win, got_q[w].win);
        chk("t5_pos", {got_q[base+w].x, got_q[base+w].y, got_q[base+w].last},
            {got_q[w].x, got_q[w].y, got_q[w].last});
      end
    end

    // K=5 on a 5x5 image: exactly one full window.
    for (int i = 0; i < 25; i++) begin
      ifb.in_valid = 1'b1;
      ifb.in_px    = 8'(i);
      @(posedge clk); #1;
    end
    ifb.in_valid = 1'b0;
    chk("k5_out_valid", ifb.out_valid, 1);
    chk("k5_out_last", ifb.out_last, 1);
    chk("k5_xy", {ifb.out_x, ifb.out_y}, 0);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        chk("k5_px", ifb.out_window[x][y], 8'(y * 5 + x));
    @(posedge clk); #1;
    chk("k5_out_valid_after", ifb.out_valid, 0);
    chk("k5_count", b_count, 1);

    chk("model_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
